// File: rtl/io_port_pkg.sv
// Shared types and defaults for the I/O port bank.
//  reg_sel_e   : which register class an SFR address selects
//  DEF_*       : default address map (P0..P3 at 80h/90h/A0h/B0h, masks E8h+, flags F8h+)
//  port_slice  : extracts field i of width w from a packed bus (bus zero-extended to MAX_BUS)
package io_port_pkg;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_DATA,
      REG_MASK,
      REG_FLAG
   } reg_sel_e;

   localparam int unsigned MAX_BUS         = 256;
   localparam logic [7:0]  DEF_BASE_ADDR   = 8'h80;
   localparam logic [7:0]  DEF_ADDR_STRIDE = 8'h10;
   localparam logic [7:0]  DEF_MASK_BASE   = 8'hE8;
   localparam logic [7:0]  DEF_FLAG_BASE   = 8'hF8;

   function automatic logic [MAX_BUS-1:0] port_slice(input logic [MAX_BUS-1:0] vec,
                                                     input int unsigned        i,
                                                     input int unsigned        w);
      logic [MAX_BUS-1:0] field_mask;
      field_mask = (MAX_BUS'(1) << w) - MAX_BUS'(1);
      return (vec >> (i * w)) & field_mask;
   endfunction

endpackage

// File: rtl/io_port_slice.sv
// One I/O port: output latch, pin synchroniser, previous-sample register,
// change mask, sticky change flags and a local read mux.
//  clock, reset      : rising-edge clock, async active-low reset
//  pin               : asynchronous pin levels of this port
//  wdata             : SFR write data
//  data_we/mask_we/flag_we : write enables for latch / mask / flag (W1C)
//  rd_sel, rmw       : register selected for read; rmw picks latch instead of pins
//  rd_data           : combinational read value of the selected register
//  latch             : output latch driven to the pads
//  flag_any          : OR of this port's change flags
module io_port_slice
   import io_port_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin,
   input  logic [WIDTH-1:0] wdata,
   input  logic             data_we,
   input  logic             mask_we,
   input  logic             flag_we,
   input  reg_sel_e         rd_sel,
   input  logic             rmw,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] latch,
   output logic             flag_any
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] flag_q;
   logic [WIDTH-1:0] latch_q;
   logic [WIDTH-1:0] synced;
   logic [WIDTH-1:0] change;
   logic [WIDTH-1:0] clr;

   assign synced = sync_q[SYNC_STAGES-1];
   assign change = synced ^ prev_q;
   assign clr    = flag_we ? wdata : '0;

   // Sync chain and prev start at all 1s, matching the weak pull-up idle level of
   // the pads, so leaving reset never looks like a pin edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '1;
         prev_q  <= '1;
         mask_q  <= '0;
         flag_q  <= '0;
         latch_q <= '1;
      end else begin
         // NOTE: non-blocking assignments let every register sample pre-edge values,
         // which is what makes the synchroniser a real shift chain.
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= synced;
         if (mask_we) mask_q  <= wdata;
         if (data_we) latch_q <= wdata;
         // Set term is OR'ed after the clear so a simultaneous new edge survives W1C.
         flag_q <= (flag_q & ~clr) | (change & mask_q);
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns rd_data and no latch is inferred.
      rd_data = '0;
      unique case (rd_sel)
         REG_DATA: rd_data = rmw ? latch_q : synced;
         REG_MASK: rd_data = mask_q;
         REG_FLAG: rd_data = flag_q;
         default:  rd_data = '0;
      endcase
   end

   assign latch    = latch_q;
   assign flag_any = |flag_q;

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_PORTS 8051-style I/O ports on the SFR bus.
//  clock, reset : rising-edge clock, async active-low reset
//  sfr_addr     : SFR address; sfr_wr / sfr_wdata : one-cycle write
//  sfr_rd, rmw  : one-cycle read; rmw returns the data latch instead of the pins
//  sfr_rdata    : registered read data (holds when no hit)
//  sfr_hit      : registered, previous-cycle sfr_rd hit a bank register
//  pin_in       : asynchronous pins, port i at [i*WIDTH +: WIDTH]
//  port_out     : data latches to the pads
//  irq          : registered OR of all change flags
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int unsigned NUM_PORTS   = 4,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  BASE_ADDR   = DEF_BASE_ADDR,
   parameter logic [7:0]  ADDR_STRIDE = DEF_ADDR_STRIDE,
   parameter logic [7:0]  MASK_BASE   = DEF_MASK_BASE,
   parameter logic [7:0]  FLAG_BASE   = DEF_FLAG_BASE
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [7:0]                 sfr_addr,
   input  logic                       sfr_wr,
   input  logic [WIDTH-1:0]           sfr_wdata,
   input  logic                       sfr_rd,
   input  logic                       rmw,
   output logic [WIDTH-1:0]           sfr_rdata,
   output logic                       sfr_hit,
   input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
   output logic [NUM_PORTS*WIDTH-1:0] port_out,
   output logic                       irq
);

   localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   reg_sel_e                 sel;
   logic [IDX_W-1:0]         port_idx;
   logic [NUM_PORTS*WIDTH-1:0] rd_bus;
   logic [NUM_PORTS-1:0]     flag_any;
   logic [WIDTH-1:0]         rd_word;
   logic [WIDTH-1:0]         rdata_q;
   logic                     hit_q;
   logic                     irq_q;

   // Address decode: the three register classes never overlap in a valid map.
   always_comb begin
      sel      = REG_NONE;
      port_idx = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (sfr_addr == BASE_ADDR + 8'(i) * ADDR_STRIDE) begin
            sel      = REG_DATA;
            port_idx = IDX_W'(i);
         end else if (sfr_addr == MASK_BASE + 8'(i)) begin
            sel      = REG_MASK;
            port_idx = IDX_W'(i);
         end else if (sfr_addr == FLAG_BASE + 8'(i)) begin
            sel      = REG_FLAG;
            port_idx = IDX_W'(i);
         end
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      logic here;
      assign here = (port_idx == IDX_W'(g));

      io_port_slice #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_slice (
         .clock    (clock),
         .reset    (reset),
         .pin      (pin_in[g*WIDTH +: WIDTH]),
         .wdata    (sfr_wdata),
         .data_we  (sfr_wr && here && (sel == REG_DATA)),
         .mask_we  (sfr_wr && here && (sel == REG_MASK)),
         .flag_we  (sfr_wr && here && (sel == REG_FLAG)),
         .rd_sel   (sel),
         .rmw      (rmw),
         .rd_data  (rd_bus[g*WIDTH +: WIDTH]),
         .latch    (port_out[g*WIDTH +: WIDTH]),
         .flag_any (flag_any[g])
      );
   end

   assign rd_word = WIDTH'(port_slice(MAX_BUS'(rd_bus), 32'(port_idx), WIDTH));

   // Read data is captured from pre-edge register values, so a same-cycle write
   // to the same address is not yet visible.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         hit_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         hit_q <= sfr_rd && (sel != REG_NONE);
         if (sfr_rd && (sel != REG_NONE)) rdata_q <= rd_word;
         irq_q <= |flag_any;
      end
   end

   assign sfr_rdata = rdata_q;
   assign sfr_hit   = hit_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with default parameters
// (4 ports x 8 bits, 2 sync stages, P0..P3 at 80h/90h/A0h/B0h).
module tb_io_port_bank;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  sfr_addr;
   logic        sfr_wr;
   logic [7:0]  sfr_wdata;
   logic        sfr_rd;
   logic        rmw;
   logic [7:0]  sfr_rdata;
   logic        sfr_hit;
   logic [31:0] pin_in;
   logic [31:0] port_out;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rd_val;
   logic       rd_hit;

   io_port_bank dut (
      .clock     (clock),
      .reset     (reset),
      .sfr_addr  (sfr_addr),
      .sfr_wr    (sfr_wr),
      .sfr_wdata (sfr_wdata),
      .sfr_rd    (sfr_rd),
      .rmw       (rmw),
      .sfr_rdata (sfr_rdata),
      .sfr_hit   (sfr_hit),
      .pin_in    (pin_in),
      .port_out  (port_out),
      .irq       (irq)
   );

   always #5 clock = ~clock;

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Bus tasks are entered at a falling edge and return at the falling edge after
   // the rising edge that performed the access.
   task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
      sfr_addr  = addr;
      sfr_wdata = data;
      sfr_wr    = 1'b1;
      @(negedge clock);
      sfr_wr    = 1'b0;
   endtask

   task automatic sfr_read(input logic [7:0] addr, input logic mode,
                           output logic [7:0] data, output logic hit);
      sfr_addr = addr;
      rmw      = mode;
      sfr_rd   = 1'b1;
      @(negedge clock);
      sfr_rd   = 1'b0;
      data     = sfr_rdata;
      hit      = sfr_hit;
   endtask

   initial begin
      reset     = 1'b0;
      sfr_addr  = 8'h00;
      sfr_wr    = 1'b0;
      sfr_wdata = 8'h00;
      sfr_rd    = 1'b0;
      rmw       = 1'b0;
      pin_in    = 32'hFFFF_FFFF;

      // 1: reset state
      #30;
      check("rst_port_out", port_out, 32'hFFFF_FFFF);
      check("rst_irq", irq, 0);
      check("rst_rdata", sfr_rdata, 0);
      check("rst_hit", sfr_hit, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      sfr_read(8'h90, 1'b1, rd_val, rd_hit);
      check("p1_latch_reset", rd_val, 8'hFF);
      check("p1_hit", rd_hit, 1);
      @(negedge clock);
      check("hit_drops_no_rd", sfr_hit, 0);

      // 2: data latch write and readback
      sfr_write(8'hA0, 8'h5A);
      check("p2_port_out", port_out[23:16], 8'h5A);
      sfr_read(8'hA0, 1'b1, rd_val, rd_hit);
      check("p2_latch_read", rd_val, 8'h5A);
      sfr_read(8'hA0, 1'b0, rd_val, rd_hit);
      check("p2_pin_read", rd_val, 8'hFF);

      // Read and write same address same cycle returns pre-write value
      sfr_addr  = 8'hB0;
      sfr_wdata = 8'h33;
      sfr_wr    = 1'b1;
      sfr_rd    = 1'b1;
      rmw       = 1'b1;
      @(negedge clock);
      sfr_wr = 1'b0;
      sfr_rd = 1'b0;
      check("rw_same_cycle_old", sfr_rdata, 8'hFF);
      check("rw_same_cycle_latch", port_out[31:24], 8'h33);

      // 3: synchronised pins versus latch
      pin_in[15:8] = 8'h3C;
      repeat (3) @(negedge clock);
      sfr_read(8'h90, 1'b0, rd_val, rd_hit);
      check("p1_pins", rd_val, 8'h3C);
      sfr_read(8'h90, 1'b1, rd_val, rd_hit);
      check("p1_latch", rd_val, 8'hFF);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("p1_flag_unmasked", rd_val, 8'h00);
      check("irq_unmasked", irq, 0);

      // 4: masked change detection and irq latency
      sfr_write(8'hE9, 8'h01);
      sfr_read(8'hE9, 1'b0, rd_val, rd_hit);
      check("p1_mask", rd_val, 8'h01);
      pin_in[15:8] = 8'h3D;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         if (k == 3) check("irq_early", irq, 0);
         if (k == 4) check("irq_rise", irq, 1);
      end
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("p1_flag_bit0", rd_val, 8'h01);
      pin_in[15:8] = 8'h3F;
      repeat (6) @(negedge clock);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("p1_flag_bit1_masked", rd_val, 8'h01);
      sfr_read(8'hF8, 1'b0, rd_val, rd_hit);
      check("p0_flag_clear", rd_val, 8'h00);

      // 5: W1C versus simultaneous set
      sfr_write(8'hF9, 8'h01);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("w1c_clears", rd_val, 8'h00);
      pin_in[15:8] = 8'h3E;
      repeat (2) @(negedge clock);
      sfr_write(8'hF9, 8'h01);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("set_beats_w1c", rd_val, 8'h01);
      @(negedge clock);
      check("irq_held", irq, 1);
      sfr_write(8'hF9, 8'h01);
      check("irq_lags_clear", irq, 1);
      @(negedge clock);
      check("irq_fall", irq, 0);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("w1c_alone", rd_val, 8'h00);

      // Clearing the mask leaves an existing flag in place
      pin_in[15:8] = 8'h3F;
      repeat (5) @(negedge clock);
      sfr_write(8'hE9, 8'h00);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("mask_clear_keeps_flag", rd_val, 8'h01);
      check("irq_after_mask_clear", irq, 1);

      // 6: unmapped read, then async reset mid-operation
      sfr_read(8'hA0, 1'b1, rd_val, rd_hit);
      check("pre_miss_read", rd_val, 8'h5A);
      sfr_read(8'h55, 1'b1, rd_val, rd_hit);
      check("miss_hit", rd_hit, 0);
      check("miss_rdata_holds", rd_val, 8'h5A);

      pin_in[15:8] = 8'h3E;
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_port_out", port_out, 32'hFFFF_FFFF);
      check("mid_rst_irq", irq, 0);
      check("mid_rst_rdata", sfr_rdata, 0);
      check("mid_rst_hit", sfr_hit, 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (6) @(negedge clock);
      check("post_rst_irq", irq, 0);
      sfr_read(8'hF9, 1'b0, rd_val, rd_hit);
      check("post_rst_flag", rd_val, 8'h00);
      sfr_read(8'hE9, 1'b0, rd_val, rd_hit);
      check("post_rst_mask", rd_val, 8'h00);
      sfr_read(8'hA0, 1'b1, rd_val, rd_hit);
      check("post_rst_latch", rd_val, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
